// File: rtl/axi4l_pkg.sv
// AXI4-Lite register bank shared definitions.
// Response codes and byte-lane helpers.
package axi4l_pkg;

   localparam logic [1:0] AXI4L_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI4L_RESP_SLVERR = 2'b10;

   function automatic int axi4l_lane_bits(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/axi4l_regbank_if.sv
// AXI4-Lite bus bundle for the register bank.
// Master drives requests, slave drives ready/response.
interface axi4l_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
);
   import axi4l_pkg::*;

   logic                  awvalid;
   logic                  awready;
   logic [ADDR_W-1:0]     awaddr;
   logic [2:0]            awprot;
   logic                  wvalid;
   logic                  wready;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_W-1:0]     araddr;
   logic [2:0]            arprot;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_W-1:0]     rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb,
      output bready, arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp,
      input  arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb,
      input  bready, arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp,
      output arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/axi4l_regbank_slot.sv
// One bank register: byte-strobe merge and write pulse.
// Read-only slots hold nothing and present zero.
module axi4l_regbank_slot
   import axi4l_pkg::*;
#(
   parameter int                DATA_W  = 32,
   parameter logic [DATA_W-1:0] RST_VAL = '0,
   parameter bit                RO      = 1'b0
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                we_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wstrb_i,
   output logic [DATA_W-1:0]   q_o,
   output logic                pulse_o
);

   localparam int NB = DATA_W / 8;

   logic              wen;
   logic [DATA_W-1:0] q_q, q_d;
   logic              pulse_q;

   assign wen = we_i & ~RO;

   always_comb begin
      q_d = q_q;
      for (int b = 0; b < NB; b++) begin
         if (wen && wstrb_i[b]) begin
            q_d[b*8 +: 8] = wdata_i[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         q_q     <= RST_VAL;
         pulse_q <= 1'b0;
      end else begin
         q_q     <= q_d;
         pulse_q <= wen;
      end
   end

   assign q_o     = RO ? '0 : q_q;
   assign pulse_o = pulse_q;

endmodule

// File: rtl/axi4l_regbank.sv
// AXI4-Lite slave register bank with strobes and RO slots.
// One write and one read outstanding, paths independent.
module axi4l_regbank
   import axi4l_pkg::*;
#(
   parameter int                NREGS   = 4,
   parameter int                DATA_W  = 32,
   parameter int                ADDR_W  = $clog2(NREGS) + axi4l_lane_bits(DATA_W),
   parameter logic [NREGS-1:0]  RO_MASK = '0,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic                    aclk,
   input  logic                    areset_n,
   axi4l_if.slave                  axi,
   output logic [NREGS*DATA_W-1:0] regs_o,
   input  logic [NREGS*DATA_W-1:0] ro_i,
   output logic [NREGS-1:0]        wr_pulse_o
);

   localparam int LB = axi4l_lane_bits(DATA_W);

   logic                  aw_set_q, w_set_q, ar_set_q;
   logic [ADDR_W-1:0]     awaddr_q, araddr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W/8-1:0]   wstrb_q;
   logic                  bvalid_q, rvalid_q;
   logic [1:0]            bresp_q, rresp_q, rresp_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic                  commit;
   logic [NREGS-1:0]      we;
   logic [DATA_W-1:0]     regs [NREGS];
   int                    widx, ridx;
   logic                  unused;

   assign unused = ^{axi.awprot, axi.arprot};

   assign axi.awready = areset_n & ~aw_set_q;
   assign axi.wready  = areset_n & ~w_set_q;
   assign axi.arready = areset_n & ~ar_set_q;
   assign axi.bvalid  = bvalid_q;
   assign axi.bresp   = bresp_q;
   assign axi.rvalid  = rvalid_q;
   assign axi.rdata   = rdata_q;
   assign axi.rresp   = rresp_q;

   assign commit = aw_set_q & w_set_q & ~bvalid_q;
   assign widx   = int'(awaddr_q >> LB);
   assign ridx   = int'(araddr_q >> LB);

   always_comb begin
      we = '0;
      for (int i = 0; i < NREGS; i++) begin
         we[i] = commit && (widx == i) && !RO_MASK[i];
      end
   end

   for (genvar i = 0; i < NREGS; i++) begin : g_slot
      axi4l_regbank_slot #(
         .DATA_W  (DATA_W),
         .RST_VAL (RST_VAL),
         .RO      (RO_MASK[i])
      ) u_slot (
         .clk_i   (aclk),
         .rst_n_i (areset_n),
         .we_i    (we[i]),
         .wdata_i (wdata_q),
         .wstrb_i (wstrb_q),
         .q_o     (regs[i]),
         .pulse_o (wr_pulse_o[i])
      );
      assign regs_o[i*DATA_W +: DATA_W] = regs[i];
   end

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         aw_set_q <= 1'b0;
         w_set_q  <= 1'b0;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bvalid_q <= 1'b0;
         bresp_q  <= AXI4L_RESP_OKAY;
      end else begin
         if (axi.awvalid && axi.awready) begin
            aw_set_q <= 1'b1;
            awaddr_q <= axi.awaddr;
         end
         if (axi.wvalid && axi.wready) begin
            w_set_q <= 1'b1;
            wdata_q <= axi.wdata;
            wstrb_q <= axi.wstrb;
         end
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= (|we) ? AXI4L_RESP_OKAY : AXI4L_RESP_SLVERR;
         end
         if (bvalid_q && axi.bready) begin
            bvalid_q <= 1'b0;
            aw_set_q <= 1'b0;
            w_set_q  <= 1'b0;
         end
      end
   end

   // RO slots read live ro_i; RW slots read the register, pre-commit on a shared edge
   always_comb begin
      rdata_d = '0;
      rresp_d = AXI4L_RESP_SLVERR;
      for (int i = 0; i < NREGS; i++) begin
         if (ridx == i) begin
            rresp_d = AXI4L_RESP_OKAY;
            rdata_d = RO_MASK[i] ? ro_i[i*DATA_W +: DATA_W] : regs[i];
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         ar_set_q <= 1'b0;
         araddr_q <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= AXI4L_RESP_OKAY;
      end else begin
         if (axi.arvalid && axi.arready) begin
            ar_set_q <= 1'b1;
            araddr_q <= axi.araddr;
         end
         if (ar_set_q && !rvalid_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
         end
         if (rvalid_q && axi.rready) begin
            rvalid_q <= 1'b0;
            ar_set_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi4l_regbank.sv
// Scoreboard bench for axi4l_regbank: NREGS=4, 32-bit, reg 2 RO.
// Expected beats queued at issue, popped by a monitor.
module tb_axi4l_regbank;
   import axi4l_pkg::*;

   localparam int         NR  = 4;
   localparam int         DW  = 32;
   localparam int         AW  = 5;
   localparam logic [3:0] ROM = 4'b0100;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  r;
   } rexp_t;

   logic aclk = 1'b0;
   logic areset_n = 1'b0;
   always #5 aclk = ~aclk;

   axi4l_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   logic [NR*DW-1:0] regs_o;
   logic [NR*DW-1:0] ro_i;
   logic [NR-1:0]    wr_pulse_o;

   axi4l_regbank #(
      .NREGS   (NR),
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .RO_MASK (ROM),
      .RST_VAL ('0)
   ) dut (
      .aclk       (aclk),
      .areset_n   (areset_n),
      .axi        (bus),
      .regs_o     (regs_o),
      .ro_i       (ro_i),
      .wr_pulse_o (wr_pulse_o)
   );

   int          checks = 0;
   int          passes = 0;
   logic [31:0] model [NR];
   logic [31:0] rov [NR];
   int          pulse_exp [NR];
   int          pulse_cnt [NR];
   logic [1:0]  bq [$];
   rexp_t       rq [$];
   int          b_issued = 0, b_seen = 0;
   int          r_issued = 0, r_seen = 0;
   bit          rnd = 1'b0;
   bit          hold_b = 1'b0;
   logic [3:0]  rom_v = ROM;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endfunction

   function automatic void push_wr(int a, logic [31:0] d, logic [3:0] s);
      int          idx;
      logic [31:0] m;
      idx = a / 4;
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
      if (idx < NR && !rom_v[idx]) begin
         model[idx] = (model[idx] & ~m) | (d & m);
         pulse_exp[idx]++;
         bq.push_back(AXI4L_RESP_OKAY);
      end else begin
         bq.push_back(AXI4L_RESP_SLVERR);
      end
      b_issued++;
   endfunction

   function automatic void push_rd(int a);
      int    idx;
      rexp_t e;
      idx = a / 4;
      if (idx >= NR) begin
         e.d = '0; e.r = AXI4L_RESP_SLVERR;
      end else begin
         e.d = rom_v[idx] ? rov[idx] : model[idx];
         e.r = AXI4L_RESP_OKAY;
      end
      rq.push_back(e);
      r_issued++;
   endfunction

   // ready driver and monitor
   initial begin
      bus.rready = 1'b1;
      bus.bready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         bus.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.bready = hold_b ? 1'b0 :
                      (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   initial begin
      rexp_t      re;
      logic [1:0] be;
      forever begin
         @(negedge aclk);
         if (!areset_n) begin
            for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
         end else begin
            if (bus.bvalid && bus.bready) begin
               b_seen++;
               if (bq.size() == 0) begin
                  checks++;
                  $display("FAIL b_unexpected: got bresp %0h with none queued", bus.bresp);
               end else begin
                  be = bq.pop_front();
                  chk("bresp", 64'(bus.bresp), 64'(be));
               end
            end
            if (bus.rvalid && bus.rready) begin
               r_seen++;
               if (rq.size() == 0) begin
                  checks++;
                  $display("FAIL r_unexpected: got rdata %0h with none queued", bus.rdata);
               end else begin
                  re = rq.pop_front();
                  chk("rdata", 64'(bus.rdata), 64'(re.d));
                  chk("rresp", 64'(bus.rresp), 64'(re.r));
               end
            end
            for (int i = 0; i < NR; i++) if (wr_pulse_o[i]) pulse_cnt[i]++;
         end
      end
   end

   task automatic send_aw(input int a);
      int n = 0;
      bus.awaddr = AW'(a);
      bus.awprot = 3'($urandom);
      bus.awvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!bus.awready && n < 100);
      if (!bus.awready) begin
         checks++;
         $display("FAIL aw_timeout: got awready 0 expected 1");
      end else @(posedge aclk);
      #1 bus.awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      bus.wdata = d;
      bus.wstrb = s;
      bus.wvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!bus.wready && n < 100);
      if (!bus.wready) begin
         checks++;
         $display("FAIL w_timeout: got wready 0 expected 1");
      end else @(posedge aclk);
      #1 bus.wvalid = 1'b0;
   endtask

   task automatic send_ar(input int a);
      int n = 0;
      bus.araddr = AW'(a);
      bus.arprot = 3'($urandom);
      bus.arvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!bus.arready && n < 100);
      if (!bus.arready) begin
         checks++;
         $display("FAIL ar_timeout: got arready 0 expected 1");
      end else @(posedge aclk);
      #1 bus.arvalid = 1'b0;
   endtask

   task automatic wait_b();
      int n = 0;
      while (b_seen < b_issued && n < 300) begin @(negedge aclk); n++; end
      if (b_seen < b_issued) begin
         checks++;
         $display("FAIL b_timeout: got %0d beats expected %0d", b_seen, b_issued);
         b_issued = b_seen;
         bq.delete();
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic wait_r();
      int n = 0;
      while (r_seen < r_issued && n < 300) begin @(negedge aclk); n++; end
      if (r_seen < r_issued) begin
         checks++;
         $display("FAIL r_timeout: got %0d beats expected %0d", r_seen, r_issued);
         r_issued = r_seen;
         rq.delete();
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic wr(input int a, input logic [31:0] d, input logic [3:0] s,
                     input int ad, input int wd);
      push_wr(a, d, s);
      fork
         begin
            if (ad > 0) begin repeat (ad) @(posedge aclk); #1; end
            send_aw(a);
         end
         begin
            if (wd > 0) begin repeat (wd) @(posedge aclk); #1; end
            send_w(d, s);
         end
      join
      wait_b();
   endtask

   task automatic rd(input int a);
      push_rd(a);
      send_ar(a);
      wait_r();
   endtask

   initial begin
      int base;
      bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
      bus.wvalid = 1'b0;  bus.wdata = '0;  bus.wstrb = '0;
      bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0;
      for (int i = 0; i < NR; i++) begin
         model[i] = '0;
         pulse_exp[i] = 0;
         rov[i] = 32'hBAD0_0000 + 32'(i);
      end
      rov[2] = 32'hCAFE_0001;
      for (int i = 0; i < NR; i++) ro_i[i*DW +: DW] = rov[i];

      repeat (3) @(negedge aclk);
      chk("rst_bvalid", 64'(bus.bvalid), 0);
      chk("rst_rvalid", 64'(bus.rvalid), 0);
      chk("rst_awready", 64'(bus.awready), 0);
      chk("rst_wready", 64'(bus.wready), 0);
      chk("rst_arready", 64'(bus.arready), 0);
      @(posedge aclk);
      #1 areset_n = 1'b1;
      @(negedge aclk);
      chk("rst_regs", 64'(regs_o), 0);
      @(posedge aclk);
      #1;
      for (int i = 0; i < NR; i++) rd(i * 4);

      wr(4, 32'hDEAD_BEEF, 4'b1111, 0, 0);
      wr(4, 32'h0000_1122, 4'b0011, 1, 0);
      rd(4);
      chk("pulse_r1_twice", 64'(pulse_cnt[1]), 2);

      // W three cycles ahead of AW, B held off
      hold_b = 1'b1;
      base = pulse_cnt[3];
      push_wr(12, 32'h1234_5678, 4'hF);
      fork
         send_w(32'h1234_5678, 4'hF);
         begin repeat (3) @(posedge aclk); #1; send_aw(12); end
      join
      @(posedge aclk);
      for (int k = 0; k < 5; k++) begin
         @(negedge aclk);
         chk("hold_bvalid", 64'(bus.bvalid), 1);
         chk("hold_awready", 64'(bus.awready), 0);
         chk("hold_wready", 64'(bus.wready), 0);
      end
      chk("hold_one_pulse", 64'(pulse_cnt[3] - base), 1);
      chk("hold_reg3", 64'(regs_o[3*DW +: DW]), 64'h1234_5678);
      hold_b = 1'b0;
      wait_b();

      base = pulse_cnt[2];
      wr(16, 32'hFFFF_FFFF, 4'hF, 0, 0);
      wr(8, 32'h0BAD_F00D, 4'hF, 0, 2);
      chk("err_regs", 64'(regs_o), {model[3], model[2], model[1], model[0]});
      chk("err_no_pulse", 64'(pulse_cnt[2] - base), 0);
      rd(16);
      rd(8);

      // read sample and write commit land on one edge
      push_rd(0);
      push_wr(0, 32'hA5A5_5A5A, 4'hF);
      fork
         send_ar(0);
         send_aw(0);
         send_w(32'hA5A5_5A5A, 4'hF);
      join
      wait_b();
      wait_r();
      rd(0);

      send_aw(0);
      #1 areset_n = 1'b0;
      for (int i = 0; i < NR; i++) begin model[i] = '0; pulse_exp[i] = 0; end
      @(negedge aclk);
      @(negedge aclk);
      chk("mid_bvalid", 64'(bus.bvalid), 0);
      chk("mid_awready", 64'(bus.awready), 0);
      @(posedge aclk);
      #1 areset_n = 1'b1;
      wr(4, 32'h55AA_1234, 4'hF, 0, 0);
      rd(0);
      rd(4);

      rnd = 1'b1;
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 1) == 1)
            wr(int'($urandom_range(0, 31)), $urandom, 4'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         else
            rd(int'($urandom_range(0, 31)));
      end
      rnd = 1'b0;
      for (int i = 0; i < NR; i++) rd(i * 4);

      repeat (3) @(negedge aclk);
      chk("bq_empty", 64'(bq.size()), 0);
      chk("rq_empty", 64'(rq.size()), 0);
      for (int i = 0; i < NR; i++) begin
         chk($sformatf("pulses_%0d", i), 64'(pulse_cnt[i]), 64'(pulse_exp[i]));
         chk($sformatf("regs_o_%0d", i), 64'(regs_o[i*DW +: DW]), 64'(model[i]));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/axi4l_regbank.md
# axi4l_regbank

Parametrised AXI4-Lite slave register bank: NREGS word registers of DATA_W bits, byte-lane write strobes, per-register read-only selection, and SLVERR responses for unmapped or illegal accesses. Sits between the AXI4-Lite interconnect and block control/status logic. Successor to the fixed two-register, 32-bit, strobe-ignoring word bank.

## Interface
- NREGS, 4: number of registers, at least 1; need not be a power of two.
- DATA_W, 32: data width, 32 or 64.
- ADDR_W, clog2(NREGS)+clog2(DATA_W/8): byte-address width.
- RO_MASK, all zeros: NREGS-bit vector; bit i=1 makes register i read-only, sourced from ro_i.
- RST_VAL, all zeros: reset value of every RW register.

Ports:
- aclk  in  1  clock.
- areset_n  in  1  reset, synchronous, active-low.
- awvalid/awready  in/out  1  AW handshake.
- awaddr  in  ADDR_W  write byte address; low clog2(DATA_W/8) bits ignored.
- awprot  in  3  ignored.
- wvalid/wready  in/out  1  W handshake.
- wdata  in  DATA_W.
- wstrb  in  DATA_W/8  byte enables.
- bvalid/bready  out/in  1  B handshake.
- bresp  out  2  OKAY 2'b00 or SLVERR 2'b10.
- arvalid/arready  in/out  1  AR handshake.
- araddr  in  ADDR_W.
- arprot  in  3  ignored.
- rvalid/rready  out/in  1  R handshake.
- rdata  out  DATA_W.
- rresp  out  2.
- regs_o  out  NREGS*DATA_W  RW register contents; register i at bits [i*DATA_W +: DATA_W]; RO slots drive 0.
- ro_i  in  NREGS*DATA_W  values of RO registers; ignored for RW slots.
- wr_pulse_o  out  NREGS  one-cycle pulse per successful write to register i.

## Operation
- Reset (areset_n low at a rising edge): RW registers to RST_VAL; bvalid, rvalid, wr_pulse_o to 0; bresp and rresp to OKAY; rdata to 0; AW/W/AR capture flags cleared. awready, wready and arready are gated low while areset_n is low.
- Write channel: AW and W are accepted independently. awready = not aw_set; wready = not w_set. Each handshake latches its address or data/strobe and sets its flag. Either order, or both in one cycle.
- Commit: on the first edge where both flags are set and bvalid is 0:
  - Word index = awaddr >> clog2(DATA_W/8).
  - Index < NREGS and RW: each byte lane with wstrb set takes the new wdata byte; other lanes hold. wr_pulse_o[index] is 1 for exactly the following cycle, even if wstrb is all zeros. bresp = OKAY.
  - Index >= NREGS, or register is RO: no state change, no pulse, bresp = SLVERR.
  - bvalid is set to 1.
- B: bvalid holds until bvalid and bready are both high. On that edge, bvalid and both flags clear, so awready and wready return to 1 the next cycle. Only one write is outstanding at a time.
- Read channel: arready = not ar_set. On the AR handshake the address is latched. The next edge loads rdata and sets rvalid:
  - RW register: current register value.
  - RO register: ro_i slice, sampled at that edge.
  - Unmapped index: rdata = 0, rresp = SLVERR.
- R: rdata and rresp are held stable while rvalid is high and rready is low. ar_set clears on the R handshake.
- Read and write paths are fully independent and may be active in the same cycle.

## Timing
- Write latency: AW and W both handshaken at edge E0 → registers updated and bvalid high after E1. If W arrives k cycles after AW, bvalid goes high k cycles later.
- Read latency: AR handshake at E0 → rvalid and rdata valid after E1.
- Same-edge read and write to one register: the read samples the pre-commit (old) value.
- bready held high: back-to-back writes sustain one write per 3 cycles. rready held high: back-to-back reads sustain one read per 3 cycles.
- Reset mid-transaction aborts it: no B or R beat is issued for it, and partially latched AW/W state is discarded.

## Structure
- Package axi4l_pkg holds:
  - the response constants (AXI4L_RESP_OKAY = 2'b00, AXI4L_RESP_SLVERR = 2'b10);
  - a clog2-based helper for byte-lane count.
- Sub-module axi4l_regbank_slot (parameters DATA_W, RST_VAL, RO):
  - one register with byte-strobe merge and wr_pulse generation;
  - instantiated NREGS times in a generate loop.
- The top level keeps the channel handshakes, address decode and read mux.

## Test plan
- Reset then read every index with NREGS=4, DATA_W=32 → all RW regs read 0x00000000 with OKAY; rvalid and bvalid are 0 during reset.
- Write 0xDEADBEEF to byte address 0x4 with wstrb=4'b1111, then write 0x00001122 with wstrb=4'b0011 → read of 0x4 returns 0xDEAD1122. wr_pulse_o[1] pulses twice.
- W presented 3 cycles before AW with bready low for 5 cycles → exactly one commit; bvalid holds; awready and wready stay low until the B handshake.
- Write to 0x10 (index 4, unmapped) and to an RO_MASK=4'b0100 register → bresp SLVERR, regs_o unchanged, no pulse. Reading 0x10 gives rdata 0 with SLVERR; reading 0x8 with ro_i slice 0xCAFE0001 returns 0xCAFE0001.
- AR and commit to the same register on the same edge → read returns the old value; a following read returns the new one.
- areset_n driven low one cycle after an AW-only handshake → after reset a fresh AW+W pair commits normally, with no stale address used.
